// File: rtl/fu_issue_ctrl_if.sv
// fu_issue_ctrl_if
// Bundle between the reservation stage / FU cluster and the issue controller.
//   in_valid/in_class/in_pkt/in_ready : enqueue handshake from the reservation stage
//   stall, done_alu/done_mult/done_br : FU cluster back-pressure and per-unit free pulses
//   issue_valid/issue_fu_select/issue_pkt : registered one-cycle issue strobe to the cluster
//   fu_busy, count                        : status (busy map by fu_select code, occupancy)
// Handshake: an entry transfers on a rising clock edge where in_valid && in_ready are
// both high; in_valid may rise without waiting for in_ready, and in_ready never
// depends on in_valid. issue_valid is a strobe with no ready; the cluster must take it.
// Modports: master = the side driving enqueue/stall/done, slave = the issue controller.
interface fu_issue_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 128
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [1:0]       in_class;
    logic [PKT_W-1:0] in_pkt;
    logic             in_ready;
    logic             stall;
    logic [2:0]       done_alu;
    logic [1:0]       done_mult;
    logic             done_br;
    logic             issue_valid;
    logic [2:0]       issue_fu_select;
    logic [PKT_W-1:0] issue_pkt;
    logic [7:0]       fu_busy;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_class, in_pkt, stall, done_alu, done_mult, done_br,
        input  in_ready, issue_valid, issue_fu_select, issue_pkt, fu_busy, count
    );

    modport slave (
        input  in_valid, in_class, in_pkt, stall, done_alu, done_mult, done_br,
        output in_ready, issue_valid, issue_fu_select, issue_pkt, fu_busy, count
    );
endinterface

// File: rtl/fu_issue_ctrl.sv
// fu_issue_ctrl
// In-order issue controller for the six-unit FU cluster (ALU_1..3, MULT_1..2, BRANCH).
// Buffers {class, pkt} entries in a circular FIFO and issues the head to the
// lowest-numbered free unit of its class, at most one per cycle.
// Ports:
//   clock  : system clock
//   reset  : asynchronous, active-high reset
//   bus    : fu_issue_ctrl_if.slave (enqueue handshake, stall, done pulses,
//            issue strobe, busy map, occupancy)
module fu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int PKT_W = 128
) (
    input  logic         clock,
    input  logic         reset,
    fu_issue_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [1:0] CLS_ALU  = 2'd0;
    localparam logic [1:0] CLS_MULT = 2'd1;
    localparam logic [1:0] CLS_BR   = 2'd2;
    localparam logic [1:0] CLS_ILL  = 2'd3;

    logic [1:0]       q_class [DEPTH];
    logic [PKT_W-1:0] q_pkt   [DEPTH];
    logic [AW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q;
    logic [7:0]       busy_q, busy_next;
    logic             issue_valid_q;
    logic [2:0]       issue_sel_q;
    logic [PKT_W-1:0] issue_pkt_q;

    logic [7:0]       done_map, avail;
    logic [1:0]       head_class;
    logic             non_empty, enq, deq, do_issue, do_drop, sel_ok;
    logic [2:0]       sel_code;

    // Done pulses laid out on the same code space as fu_busy / issue_fu_select.
    assign done_map   = {bus.done_br, bus.done_mult, bus.done_alu, 2'b00};
    // A unit finishing this cycle is already selectable this cycle.
    assign avail      = ~busy_q | done_map;
    assign head_class = q_class[head_q];
    assign non_empty  = (count_q != '0);
    assign enq        = bus.in_valid && bus.in_ready;

    always_comb begin
        sel_ok   = 1'b0;
        sel_code = 3'd0;
        case (head_class)
            CLS_ALU: begin
                if (avail[2])      begin sel_ok = 1'b1; sel_code = 3'd2; end
                else if (avail[3]) begin sel_ok = 1'b1; sel_code = 3'd3; end
                else if (avail[4]) begin sel_ok = 1'b1; sel_code = 3'd4; end
            end
            CLS_MULT: begin
                if (avail[5])      begin sel_ok = 1'b1; sel_code = 3'd5; end
                else if (avail[6]) begin sel_ok = 1'b1; sel_code = 3'd6; end
            end
            CLS_BR: begin
                if (avail[7])      begin sel_ok = 1'b1; sel_code = 3'd7; end
            end
            default: ;
        endcase
    end

    assign do_issue = non_empty && !bus.stall && sel_ok;
    // Illegal-class entries are flushed even under stall so they never wedge the head.
    assign do_drop  = non_empty && (head_class == CLS_ILL);
    assign deq      = do_issue || do_drop;

    // Issue setting a bit is applied after done clearing, so it wins on the same unit.
    always_comb begin
        busy_next = busy_q & ~done_map;
        if (do_issue) begin
            busy_next[sel_code] = 1'b1;
        end
        busy_next[1:0] = 2'b00;
    end

    // Payload storage has no reset; validity is carried entirely by count/pointers.
    always_ff @(posedge clock) begin
        if (enq) begin
            q_class[tail_q] <= bus.in_class;
            q_pkt[tail_q]   <= bus.in_pkt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_sel_q   <= 3'd0;
            issue_pkt_q   <= '0;
        end else begin
            busy_q <= busy_next;
            if (enq) begin
                tail_q <= tail_q + 1'b1;
            end
            if (deq) begin
                head_q <= head_q + 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (do_issue) begin
                issue_valid_q <= 1'b1;
                issue_sel_q   <= sel_code;
                issue_pkt_q   <= q_pkt[head_q];
            end else begin
                issue_valid_q <= 1'b0;
                issue_sel_q   <= 3'd0;
                issue_pkt_q   <= '0;
            end
        end
    end

    assign bus.in_ready        = (count_q != FULL);
    assign bus.count           = count_q;
    assign bus.fu_busy         = busy_q;
    assign bus.issue_valid     = issue_valid_q;
    assign bus.issue_fu_select = issue_sel_q;
    assign bus.issue_pkt       = issue_pkt_q;
endmodule
